// File: rtl/sprite_drawer_if.sv
// Sprite draw job, pattern ROM and line-buffer signals between the scheduler side and the drawer.
// master = scheduler/ROM/line-buffer environment, slave = sprite_drawer.
interface sprite_drawer_if #(
   parameter int PIX_W = 8
);
   logic             draw_req;
   logic [9:0]       col_base;
   logic             flip;
   logic [7:0]       frame_id;
   logic [3:0]       row_off;
   logic             draw_done;
   logic             rom_rd;
   logic [15:0]      rom_addr;
   logic [PIX_W-1:0] rom_data;
   logic             lb_we;
   logic [9:0]       lb_addr;
   logic [PIX_W-1:0] lb_wdata;

   modport master (
      output draw_req, col_base, flip, frame_id, row_off, rom_data,
      input  draw_done, rom_rd, rom_addr, lb_we, lb_addr, lb_wdata
   );

   modport slave (
      input  draw_req, col_base, flip, frame_id, row_off, rom_data,
      output draw_done, rom_rd, rom_addr, lb_we, lb_addr, lb_wdata
   );
endinterface

// File: rtl/sprite_drawer.sv
// Fetches one 16-pixel sprite row from the pattern ROM and writes it into the next-line buffer.
// Optional macro SPRITE_TRANSPARENCY_EN: palette index 0 is treated as transparent and not written.
module sprite_drawer #(
   parameter int SPR_W  = 16,
   parameter int PIX_W  = 8,
   parameter int LINE_W = 640
) (
   input logic             clk,
   input logic             reset,
   sprite_drawer_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [3:0]  LAST_PX  = 4'(SPR_W - 1);
   localparam logic [10:0] LINE_END = 11'(LINE_W);

   logic [1:0]       state;
   logic [3:0]       px;
   logic [3:0]       px_d;
   logic             rd_d;
   logic [9:0]       col_l;
   logic             flip_l;
   logic [7:0]       frame_l;
   logic [3:0]       row_l;

   logic [3:0]       pix_idx;
   logic [10:0]      col;
   logic             opaque;
   logic [PIX_W-1:0] pix_data;

   // Job acceptance and the 16-cycle fetch; (rd_d, px_d) tracks which pixel rom_data carries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         px      <= '0;
         px_d    <= '0;
         rd_d    <= 1'b0;
         col_l   <= '0;
         flip_l  <= 1'b0;
         frame_l <= '0;
         row_l   <= '0;
      end else begin
         rd_d <= (state == FETCH);
         px_d <= px;
         case (state)
            IDLE: begin
               if (bus.draw_req) begin
                  col_l   <= bus.col_base;
                  flip_l  <= bus.flip;
                  frame_l <= bus.frame_id;
                  row_l   <= bus.row_off;
                  px      <= '0;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               px <= px + 4'd1;
               if (px == LAST_PX) begin
                  state <= DRAIN;
               end
            end
            DRAIN:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The column sum is 11 bits wide so sprites hanging off the right edge clip instead of wrapping.
   always_comb begin
      pix_idx  = flip_l ? (LAST_PX - px_d) : px_d;
      col      = {1'b0, col_l} + {7'd0, pix_idx};
      pix_data = bus.rom_data;
`ifdef SPRITE_TRANSPARENCY_EN
      opaque   = (pix_data != '0);
`else
      opaque   = 1'b1;
`endif
   end

   assign bus.draw_done = (state == IDLE);
   assign bus.rom_rd    = (state == FETCH);
   assign bus.rom_addr  = (state == FETCH) ? {frame_l, row_l, px} : 16'd0;
   assign bus.lb_we     = rd_d && (col < LINE_END) && opaque;
   assign bus.lb_addr   = rd_d ? col[9:0] : 10'd0;
   assign bus.lb_wdata  = rd_d ? pix_data : '0;

endmodule

// File: tb/tb_sprite_drawer.sv
// Self-checking bench for sprite_drawer: a job-level model checked every cycle plus literal spot checks.
// Honours SPRITE_TRANSPARENCY_EN when the build defines it.
module tb_sprite_drawer;

`ifdef SPRITE_TRANSPARENCY_EN
   localparam bit TRANSP = 1'b1;
`else
   localparam bit TRANSP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sprite_drawer_if #(.PIX_W(8)) bus ();

   sprite_drawer #(.SPR_W(16), .PIX_W(8), .LINE_W(640)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int romMode     = 0;
   int writesSeen  = 0;
   int lineBuf [1024];

   // Model state: whether a job is in flight and which of its 17 busy cycles we are in
   bit mBusy = 1'b0;
   int mJ    = 0;
   int mCol, mFlip, mFid, mRow;

   function automatic int romFunc(input int p);
      if (romMode == 1 && (p % 2) == 0) return 0;
      return p + 1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Pattern ROM with the one-cycle read latency the drawer expects
   always @(posedge clk) begin
      bus.rom_data <= bus.rom_rd ? 8'(romFunc(int'(bus.rom_addr[3:0]))) : 8'hEE;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mBusy <= 1'b0;
         mJ    <= 0;
      end else if (!mBusy) begin
         if (bus.draw_req === 1'b1) begin
            mBusy <= 1'b1;
            mJ    <= 0;
            mCol  <= int'(bus.col_base);
            mFlip <= int'(bus.flip);
            mFid  <= int'(bus.frame_id);
            mRow  <= int'(bus.row_off);
         end
      end else if (mJ == 16) begin
         mBusy <= 1'b0;
      end else begin
         mJ <= mJ + 1;
      end
   end

   // Every cycle: busy cycle j fetches pixel j (j<16) and writes pixel j-1 (j>=1)
   always @(negedge clk) begin
      automatic int  p;
      automatic int  col;
      automatic int  d;
      automatic bit  expRd;
      automatic bit  expWe;
      checkOutput("draw_done", int'(bus.draw_done), mBusy ? 0 : 1);
      expRd = mBusy && (mJ < 16);
      checkOutput("rom_rd", int'(bus.rom_rd), int'(expRd));
      if (expRd) checkOutput("rom_addr", int'(bus.rom_addr), mFid * 256 + mRow * 16 + mJ);
      expWe = 1'b0;
      col   = 0;
      d     = 0;
      if (mBusy && mJ >= 1) begin
         p     = mJ - 1;
         col   = mCol + (mFlip != 0 ? 15 - p : p);
         d     = romFunc(p);
         expWe = (col < 640) && (!TRANSP || d != 0);
      end
      checkOutput("lb_we", int'(bus.lb_we), int'(expWe));
      if (expWe) begin
         checkOutput("lb_addr", int'(bus.lb_addr), col);
         checkOutput("lb_wdata", int'(bus.lb_wdata), d);
      end
   end

   always @(negedge clk) begin
      if (bus.lb_we === 1'b1) begin
         lineBuf[bus.lb_addr] = int'(bus.lb_wdata);
         writesSeen++;
      end
   end

   task automatic clearLine();
      for (int i = 0; i < 1024; i++) lineBuf[i] = -1;
      writesSeen = 0;
   endtask

   // Issues one job, then measures the busy window and the first ROM address
   task automatic applyStimulus(input int col, input int fl, input int fid, input int roff,
                                output int busyLen, output int firstAddr);
      int guard;
      busyLen   = 0;
      firstAddr = -1;
      @(posedge clk); #1;
      bus.col_base = 10'(col);
      bus.flip     = fl[0];
      bus.frame_id = 8'(fid);
      bus.row_off  = 4'(roff);
      bus.draw_req = 1'b1;
      @(negedge clk);
      checkOutput("done_in_req_cycle", int'(bus.draw_done), 1);
      @(posedge clk); #1;
      bus.draw_req = 1'b0;
      guard = 0;
      forever begin
         @(negedge clk);
         if (bus.draw_done === 1'b1) break;
         if (busyLen == 0) firstAddr = int'(bus.rom_addr);
         busyLen++;
         guard++;
         if (guard > 40) begin
            checkOutput("busy_timeout", busyLen, 17);
            break;
         end
      end
   endtask

   int busyLen, firstAddr, writesAtReset;

   initial begin
      bus.draw_req = 1'b0;
      bus.col_base = '0;
      bus.flip     = 1'b0;
      bus.frame_id = '0;
      bus.row_off  = '0;
      clearLine();
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idle_done", int'(bus.draw_done), 1);
      checkOutput("idle_lb_we", int'(bus.lb_we), 0);

      // Basic job
      clearLine();
      applyStimulus(100, 0, 8'h05, 3, busyLen, firstAddr);
      checkOutput("basic_busy", busyLen, 17);
      checkOutput("basic_first_addr", firstAddr, 16'h0530);
      checkOutput("basic_writes", writesSeen, 16);
      checkOutput("basic_col100", lineBuf[100], 1);
      checkOutput("basic_col115", lineBuf[115], 16);

      // Mirrored
      clearLine();
      applyStimulus(100, 1, 8'h05, 3, busyLen, firstAddr);
      checkOutput("flip_busy", busyLen, 17);
      checkOutput("flip_col115", lineBuf[115], 1);
      checkOutput("flip_col100", lineBuf[100], 16);

      // Right-edge clipping
      clearLine();
      applyStimulus(632, 0, 8'h21, 9, busyLen, firstAddr);
      checkOutput("clip632_busy", busyLen, 17);
      checkOutput("clip632_writes", writesSeen, 8);
      checkOutput("clip632_col639", lineBuf[639], 8);
      checkOutput("clip632_nowrap", lineBuf[0], -1);
      clearLine();
      applyStimulus(700, 0, 8'h21, 9, busyLen, firstAddr);
      checkOutput("clip700_busy", busyLen, 17);
      checkOutput("clip700_writes", writesSeen, 0);

      // Requests during busy cycles 5 and 17 are ignored; cycle 18 starts the next job
      clearLine();
      for (int c = 0; c <= 19; c++) begin
         @(posedge clk); #1;
         case (c)
            0: begin
               bus.col_base = 10'd400; bus.flip = 1'b0;
               bus.frame_id = 8'h11;   bus.row_off = 4'd2;
               bus.draw_req = 1'b1;
            end
            1:  bus.draw_req = 1'b0;
            5:  begin bus.col_base = 10'd300; bus.draw_req = 1'b1; end
            6:  bus.draw_req = 1'b0;
            17: begin
               bus.col_base = 10'd300; bus.draw_req = 1'b1;
               @(negedge clk);
               checkOutput("stress_busy_c17", int'(bus.draw_done), 0);
            end
            18: begin
               bus.col_base = 10'd200; bus.frame_id = 8'h22; bus.row_off = 4'd7;
               @(negedge clk);
               checkOutput("stress_done_c18", int'(bus.draw_done), 1);
            end
            19: begin
               bus.draw_req = 1'b0;
               @(negedge clk);
               checkOutput("stress_busy_c19", int'(bus.draw_done), 0);
            end
            default: ;
         endcase
      end
      busyLen = 1;
      forever begin
         @(negedge clk);
         if (bus.draw_done === 1'b1 || busyLen > 40) break;
         busyLen++;
      end
      checkOutput("stress_busy", busyLen, 17);
      checkOutput("stress_col300", lineBuf[300], -1);
      checkOutput("stress_col400", lineBuf[400], 1);
      checkOutput("stress_col200", lineBuf[200], 1);
      checkOutput("stress_writes", writesSeen, 32);

      // ROM returns 0 for even pixels
      clearLine();
      romMode = 1;
      applyStimulus(50, 0, 8'h33, 1, busyLen, firstAddr);
      checkOutput("zero_busy", busyLen, 17);
      checkOutput("zero_writes", writesSeen, TRANSP ? 8 : 16);
      checkOutput("zero_col51", lineBuf[51], 2);
      checkOutput("zero_col50", lineBuf[50], TRANSP ? -1 : 0);
      romMode = 0;

      // Reset during FETCH cycle 6
      clearLine();
      @(posedge clk); #1;
      bus.col_base = 10'd10; bus.flip = 1'b0; bus.frame_id = 8'h44; bus.row_off = 4'd0;
      bus.draw_req = 1'b1;
      @(posedge clk); #1;
      bus.draw_req = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("rst_done", int'(bus.draw_done), 1);
      checkOutput("rst_lb_we", int'(bus.lb_we), 0);
      checkOutput("rst_rom_rd", int'(bus.rom_rd), 0);
      writesAtReset = writesSeen;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("rst_no_more_writes", writesSeen, writesAtReset);
      checkOutput("rst_writes_before", writesAtReset, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
